multiword_add_sequencer: RTL and testbench

- Sequential front/back-end for the 8-bit hybrid CLA/ripple adder.
- Accepts two NBYTES-wide operands over a valid/ready handshake.
- Drives the adder one byte per cycle, LSB first, feeding the adder's carry-out (C8) back as the next byte's carry-in (C0).
- Collects the result bytes and presents sum, carry-out, signed overflow and zero flags on a valid/ready output port.
- The adder stays an external combinational instance. This block drives its X/Y/C0 inputs and consumes its S/C8 outputs.

---
 rtl/mwadd_pkg.sv | 24 ++
 rtl/multiword_add_sequencer_if.sv | 36 +++
 rtl/mwadd_byte_shreg.sv | 32 +++
 rtl/multiword_add_sequencer.sv | 141 ++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mwadd_pkg.sv
// Shared constants for the multiword add sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mwadd_pkg;

    // The external adder is byte-wide.
    localparam int BYTE_W = 8;

    // Operand width limits, in bytes.
    localparam int NBYTES_MIN = 1;
    localparam int NBYTES_MAX = 16;

    // State encoding; plain constants keep the register a flat logic vector.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Byte index width: clog2(nbytes), never narrower than one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Operand request and result response bundle for the multiword add sequencer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface multiword_add_sequencer_if #(
    parameter int NBYTES = 4
);
    import mwadd_pkg::*;

    localparam int W = BYTE_W * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    // The sequencer itself.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/mwadd_byte_shreg.sv
// Operand register: parallel load, then shift right one byte per cycle, low byte exposed.
// Latency: low byte valid the cycle after load; each shift advances one byte.
// Backpressure: none; load and shift are sampled every edge, load wins.
module mwadd_byte_shreg
    import mwadd_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [W-1:0]      din,
    output logic [BYTE_W-1:0] lsb
);

    logic [W-1:0] q;

    // Load a whole operand, or move the next byte down into the low lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q >> BYTE_W;
        end
    end

    assign lsb = q[BYTE_W-1:0];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Serialises a W-bit add onto an external 8-bit adder, LSB byte first, rippling C8 into C0.
// Latency: out_valid rises NBYTES edges after the accepting edge; next accept NBYTES+2 cycles later at best.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module multiword_add_sequencer
    import mwadd_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multiword_add_sequencer_if.slave  bus,
    output logic [BYTE_W-1:0]         add_x,
    output logic [BYTE_W-1:0]         add_y,
    output logic                      add_c0,
    input  logic [BYTE_W-1:0]         add_s,
    input  logic                      add_c8
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = idx_width(NBYTES);

    if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
        $error("multiword_add_sequencer: NBYTES=%0d outside %0d..%0d", NBYTES, NBYTES_MIN, NBYTES_MAX);
    end

    state_t            state;
    logic              carry_reg;
    logic [IW-1:0]     idx;
    logic              a_sign;
    logic              b_sign;
    logic [W-1:0]      res;
    logic [W-1:0]      res_next;
    logic [BYTE_W-1:0] a_lsb;
    logic [BYTE_W-1:0] b_lsb;

    logic [W-1:0]      sum_r;
    logic              cout_r;
    logic              ovf_r;
    logic              zero_r;

    logic              load;
    logic              running;
    logic              last;

    assign load    = (state == ST_IDLE) && bus.in_valid;
    assign running = (state == ST_RUN);
    assign last    = running && (idx == IW'(NBYTES - 1));

    mwadd_byte_shreg #(.W(W)) u_shreg_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (running),
        .din   (bus.a),
        .lsb   (a_lsb)
    );

    mwadd_byte_shreg #(.W(W)) u_shreg_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (running),
        .din   (bus.b),
        .lsb   (b_lsb)
    );

    // Adder inputs are only live while RUN so the adder sees quiet zeros otherwise.
    assign add_x  = running ? a_lsb : '0;
    assign add_y  = running ? b_lsb : '0;
    assign add_c0 = running ? carry_reg : 1'b0;

    // Result bytes so far with this cycle's adder byte merged in at its lane.
    always_comb begin
        res_next = res;
        res_next[int'(idx) * BYTE_W +: BYTE_W] = add_s;
    end

    // Sequencing: accept, walk NBYTES bytes with carry feedback, then hold for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            carry_reg <= 1'b0;
            idx       <= '0;
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
            res       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        carry_reg <= bus.cin;
                        idx       <= '0;
                        a_sign    <= bus.a[W-1];
                        b_sign    <= bus.b[W-1];
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res       <= res_next;
                    carry_reg <= add_c8;
                    if (last) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result port registers update only on the final byte, so nothing partial ever shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (last) begin
            sum_r  <= res_next;
            cout_r <= add_c8;
            ovf_r  <= (a_sign == b_sign) && (res_next[W-1] != a_sign);
            zero_r <= (res_next == '0);
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: NBYTES=4 and NBYTES=1 builds, each with a behavioural adder.
// Latency: checks result NBYTES edges after accept and per-byte adder drive.
// Backpressure: holds out_ready low in DONE and checks the result stays put.
module tb_multiword_add_sequencer;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    res_t q4[$];
    res_t q1[$];

    multiword_add_sequencer_if #(.NBYTES(4)) if4 ();
    multiword_add_sequencer_if #(.NBYTES(1)) if1 ();

    logic [7:0] add_x4, add_y4, add_s4;
    logic       add_c0_4, add_c8_4;
    logic [7:0] add_x1, add_y1, add_s1;
    logic       add_c0_1, add_c8_1;

    // Behavioural byte adders standing in for the external CLA/ripple adder.
    assign {add_c8_4, add_s4} = {1'b0, add_x4} + {1'b0, add_y4} + {8'd0, add_c0_4};
    assign {add_c8_1, add_s1} = {1'b0, add_x1} + {1'b0, add_y1} + {8'd0, add_c0_1};

    multiword_add_sequencer #(.NBYTES(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (if4.slave),
        .add_x  (add_x4),
        .add_y  (add_y4),
        .add_c0 (add_c0_4),
        .add_s  (add_s4),
        .add_c8 (add_c8_4)
    );

    multiword_add_sequencer #(.NBYTES(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (if1.slave),
        .add_x  (add_x1),
        .add_y  (add_y1),
        .add_c0 (add_c0_1),
        .add_s  (add_s1),
        .add_c8 (add_c8_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model4(input logic [31:0] a, input logic [31:0] b, input logic c);
        res_t        r;
        logic [32:0] t;
        t      = {1'b0, a} + {1'b0, b} + {32'd0, c};
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (a[31] == b[31]) && (t[31] != a[31]);
        r.zero = (t[31:0] == 32'd0);
        return r;
    endfunction

    function automatic res_t model1(input logic [7:0] a, input logic [7:0] b, input logic c);
        res_t       r;
        logic [8:0] t;
        t      = {1'b0, a} + {1'b0, b} + {8'd0, c};
        r.sum  = {24'd0, t[7:0]};
        r.cout = t[8];
        r.ovf  = (a[7] == b[7]) && (t[7] != a[7]);
        r.zero = (t[7:0] == 8'd0);
        return r;
    endfunction

    // Scoreboard for the 4-byte build: pop on every result handshake.
    always @(negedge clk) begin
        if (rst_n && if4.out_valid && if4.out_ready) begin
            if (q4.size() == 0) begin
                check("sb4_unexpected_result", 64'd1, 64'd0);
            end else begin
                res_t e;
                e = q4.pop_front();
                check("sb4_sum",  {32'd0, if4.sum}, {32'd0, e.sum});
                check("sb4_cout", {63'd0, if4.cout}, {63'd0, e.cout});
                check("sb4_ovf",  {63'd0, if4.ovf},  {63'd0, e.ovf});
                check("sb4_zero", {63'd0, if4.zero}, {63'd0, e.zero});
            end
        end
    end

    // Scoreboard for the 1-byte build.
    always @(negedge clk) begin
        if (rst_n && if1.out_valid && if1.out_ready) begin
            if (q1.size() == 0) begin
                check("sb1_unexpected_result", 64'd1, 64'd0);
            end else begin
                res_t e;
                e = q1.pop_front();
                check("sb1_sum",  {56'd0, if1.sum}, {56'd0, e.sum[7:0]});
                check("sb1_cout", {63'd0, if1.cout}, {63'd0, e.cout});
                check("sb1_ovf",  {63'd0, if1.ovf},  {63'd0, e.ovf});
                check("sb1_zero", {63'd0, if1.zero}, {63'd0, e.zero});
            end
        end
    end

    // One 4-byte transaction with per-byte adder checks; hold>0 stalls the consumer that many cycles.
    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic c, input int hold);
        int         w;
        logic       c0;
        logic [8:0] t;
        res_t       e;
        e = model4(a, b, c);
        w = 0;
        @(negedge clk);
        while (!if4.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", {63'd0, if4.in_ready}, 64'd1);
        if4.a         = a;
        if4.b         = b;
        if4.cin       = c;
        if4.in_valid  = 1'b1;
        if4.out_ready = (hold == 0);
        q4.push_back(e);
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
        if4.a        = ~a;
        if4.b        = ~b;
        c0 = c;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("add_x",     {56'd0, add_x4},   {56'd0, a[8*k +: 8]});
            check("add_y",     {56'd0, add_y4},   {56'd0, b[8*k +: 8]});
            check("add_c0",    {63'd0, add_c0_4}, {63'd0, c0});
            check("run_no_valid", {63'd0, if4.out_valid}, 64'd0);
            t  = {1'b0, a[8*k +: 8]} + {1'b0, b[8*k +: 8]} + {8'd0, c0};
            c0 = t[8];
        end
        @(negedge clk);
        check("latency_out_valid", {63'd0, if4.out_valid}, 64'd1);
        if (hold > 0) begin
            // A new request offered while DONE must be ignored.
            if4.in_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_out_valid", {63'd0, if4.out_valid}, 64'd1);
                check("hold_in_ready",  {63'd0, if4.in_ready},  64'd0);
                check("hold_sum",       {32'd0, if4.sum},       {32'd0, e.sum});
                check("hold_flags",     {61'd0, if4.cout, if4.ovf, if4.zero}, {61'd0, e.cout, e.ovf, e.zero});
            end
            @(posedge clk);
            #1;
            if4.in_valid  = 1'b0;
            if4.out_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        check("back_to_idle_in_ready", {63'd0, if4.in_ready},  64'd1);
        check("single_cycle_valid",    {63'd0, if4.out_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b1;
        #1;
        check("rst_in_ready",  {63'd0, if4.in_ready},  64'd1);
        check("rst_out_valid", {63'd0, if4.out_valid}, 64'd0);
        check("rst_sum",       {32'd0, if4.sum},       64'd0);
        check("rst_flags",     {61'd0, if4.cout, if4.ovf, if4.zero}, 64'd0);
        check("rst_add_x",     {56'd0, add_x4},        64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run4(32'h1234_5678, 32'h1111_1111, 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            run4($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
        end

        // Abort during the second RUN cycle; the aborted add must never appear.
        @(negedge clk);
        if4.a = 32'h0101_0101; if4.b = 32'h0202_0202; if4.cin = 1'b1;
        if4.in_valid = 1'b1; if4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  {63'd0, if4.in_ready},  64'd1);
        check("abort_out_valid", {63'd0, if4.out_valid}, 64'd0);
        check("abort_sum",       {32'd0, if4.sum},       64'd0);
        check("abort_flags",     {61'd0, if4.cout, if4.ovf, if4.zero}, 64'd0);
        check("abort_add_c0",    {63'd0, add_c0_4},      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_result", {63'd0, if4.out_valid}, 64'd0);
        end
        run4(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 0);

        // Single-byte build.
        @(negedge clk);
        check("nb1_in_ready", {63'd0, if1.in_ready}, 64'd1);
        if1.a = 8'h80; if1.b = 8'h80; if1.cin = 1'b0;
        if1.in_valid = 1'b1; if1.out_ready = 1'b1;
        q1.push_back(model1(8'h80, 8'h80, 1'b0));
        @(posedge clk);
        #1;
        if1.in_valid = 1'b0;
        @(negedge clk);
        check("nb1_add_x",     {56'd0, add_x1},        64'h80);
        check("nb1_add_y",     {56'd0, add_y1},        64'h80);
        check("nb1_run_valid", {63'd0, if1.out_valid}, 64'd0);
        @(negedge clk);
        check("nb1_latency",   {63'd0, if1.out_valid}, 64'd1);
        @(negedge clk);
        check("nb1_idle",      {63'd0, if1.in_ready},  64'd1);

        repeat (2) @(negedge clk);
        check("sb4_drained", 64'(q4.size()), 64'd0);
        check("sb1_drained", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
